core_task_server: RTL and testbench

//  Responder for one core's task-dequeue / start / finish / abort protocol; sits between the

---
 rtl/core_task_server.sv | 161 ++++++++++++++++
 tb/tb_core_task_server.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_task_server.sv
// rtl/core_task_server.sv - per-core task dequeue/start/finish/abort responder with ready-task buffer
module core_task_server #(
    parameter int TASK_W     = 128,
    parameter int TTYPE_W    = 4,
    parameter int SLOT_W     = 7,
    parameter int CHILD_W    = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [TASK_W-1:0]   in_task,
    input  logic [TTYPE_W-1:0]  in_ttype,
    input  logic [SLOT_W-1:0]   in_slot,
    input  logic                task_arvalid,
    input  logic [TTYPE_W-1:0]  task_araddr,
    output logic                task_rvalid,
    output logic [TASK_W-1:0]   task_rdata,
    output logic [SLOT_W-1:0]   task_rslot,
    input  logic                start_task_valid,
    output logic                start_task_ready,
    input  logic [SLOT_W-1:0]   start_task_slot,
    input  logic                finish_task_valid,
    output logic                finish_task_ready,
    input  logic [SLOT_W-1:0]   finish_task_slot,
    input  logic [CHILD_W-1:0]  finish_task_num_children,
    input  logic                finish_task_undo_log_write,
    input  logic                abort_req_valid,
    input  logic [SLOT_W-1:0]   abort_req_slot,
    output logic                abort_req_hit,
    output logic                abort_running_task,
    output logic [SLOT_W-1:0]   abort_running_slot,
    output logic                done_valid,
    input  logic                done_ready,
    output logic [SLOT_W-1:0]   done_slot,
    output logic [CHILD_W-1:0]  done_children,
    output logic                done_undo,
    output logic                done_aborted,
    output logic                proto_err
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_DISPATCHED, S_RUNNING, S_REPORT} state_t;

    state_t              state, state_nxt;
    logic [TASK_W-1:0]   fifo_task  [FIFO_DEPTH];
    logic [TTYPE_W-1:0]  fifo_ttype [FIFO_DEPTH];
    logic [SLOT_W-1:0]   fifo_slot  [FIFO_DEPTH];
    logic [PTR_W-1:0]    head, tail;
    logic [CNT_W-1:0]    count;
    logic                run_en;
    logic [SLOT_W-1:0]   cur_slot;
    logic                aborted;
    logic                push, pop, fifo_empty;
    logic                start_hs, finish_hs, abort_hit_now;

    // run_en holds in_ready low while in reset and for the first cycle after release
    assign fifo_empty  = (count == '0);
    assign in_ready    = run_en & (count != CNT_W'(FIFO_DEPTH));
    assign push        = in_valid & in_ready;
    assign task_rvalid = task_arvalid & (state == S_IDLE) & !fifo_empty
                         & (fifo_ttype[head] == task_araddr);
    assign pop         = task_rvalid;
    assign task_rdata  = task_rvalid ? fifo_task[head] : '0;
    assign task_rslot  = task_rvalid ? fifo_slot[head] : '0;

    assign start_hs      = start_task_valid & start_task_ready;
    assign finish_hs     = finish_task_valid & finish_task_ready;
    assign abort_hit_now = abort_req_valid & (abort_req_slot == cur_slot)
                           & ((state == S_DISPATCHED) | (state == S_RUNNING));

    // the abort level to the core drops as soon as the finish handshake moves us to REPORT
    assign abort_running_task = aborted & (state != S_REPORT);
    assign abort_running_slot = cur_slot;
    assign done_slot          = cur_slot;

    // ready-task storage; contents are don't-care while empty so no reset is needed
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_task[tail]  <= in_task;
            fifo_ttype[tail] <= in_ttype;
            fifo_slot[tail]  <= in_slot;
        end
    end

    // FIFO pointers and occupancy; power-of-two depth lets pointers wrap naturally
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            head   <= '0;
            tail   <= '0;
            count  <= '0;
            run_en <= 1'b0;
        end else begin
            run_en <= 1'b1;
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // task lifecycle state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // lifecycle next-state and per-state handshake readies
    always_comb begin
        state_nxt         = state;
        start_task_ready  = 1'b0;
        finish_task_ready = 1'b0;
        done_valid        = 1'b0;
        case (state)
            S_IDLE: begin
                if (pop) state_nxt = S_DISPATCHED;
            end
            S_DISPATCHED: begin
                start_task_ready = 1'b1;
                if (start_hs) state_nxt = S_RUNNING;
            end
            S_RUNNING: begin
                finish_task_ready = 1'b1;
                if (finish_hs) state_nxt = S_REPORT;
            end
            S_REPORT: begin
                done_valid = 1'b1;
                if (done_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // in-flight task bookkeeping, abort tracking, completion record and sticky error
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cur_slot      <= '0;
            aborted       <= 1'b0;
            abort_req_hit <= 1'b0;
            done_children <= '0;
            done_undo     <= 1'b0;
            done_aborted  <= 1'b0;
            proto_err     <= 1'b0;
        end else begin
            abort_req_hit <= abort_hit_now;
            if (pop) cur_slot <= fifo_slot[head];
            if ((state == S_REPORT) && done_ready) aborted <= 1'b0;
            else if (abort_hit_now)                aborted <= 1'b1;
            if (finish_hs) begin
                done_children <= finish_task_num_children;
                done_undo     <= finish_task_undo_log_write;
                done_aborted  <= aborted | abort_hit_now;
            end
            if ((start_hs && (start_task_slot != cur_slot))
                || (finish_hs && (finish_task_slot != cur_slot))
                || ((state == S_DISPATCHED) && finish_task_valid))
                proto_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_core_task_server.sv
// tb/tb_core_task_server.sv - self-checking bench for core_task_server
module tb_core_task_server;
    localparam int TASK_W = 128, TTYPE_W = 4, SLOT_W = 7, CHILD_W = 3, FIFO_DEPTH = 4;

    logic clk = 1'b0;
    logic rstn = 1'b1;
    logic in_valid = 0, in_ready;
    logic [TASK_W-1:0] in_task = '0;
    logic [TTYPE_W-1:0] in_ttype = '0;
    logic [SLOT_W-1:0] in_slot = '0;
    logic task_arvalid = 0, task_rvalid;
    logic [TTYPE_W-1:0] task_araddr = '0;
    logic [TASK_W-1:0] task_rdata;
    logic [SLOT_W-1:0] task_rslot;
    logic start_task_valid = 0, start_task_ready;
    logic [SLOT_W-1:0] start_task_slot = '0;
    logic finish_task_valid = 0, finish_task_ready;
    logic [SLOT_W-1:0] finish_task_slot = '0;
    logic [CHILD_W-1:0] finish_task_num_children = '0;
    logic finish_task_undo_log_write = 0;
    logic abort_req_valid = 0, abort_req_hit, abort_running_task;
    logic [SLOT_W-1:0] abort_req_slot = '0, abort_running_slot;
    logic done_valid, done_ready = 0;
    logic [SLOT_W-1:0] done_slot;
    logic [CHILD_W-1:0] done_children;
    logic done_undo, done_aborted, proto_err;

    core_task_server #(
        .TASK_W(TASK_W), .TTYPE_W(TTYPE_W), .SLOT_W(SLOT_W),
        .CHILD_W(CHILD_W), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .rstn(rstn),
        .in_valid(in_valid), .in_ready(in_ready), .in_task(in_task),
        .in_ttype(in_ttype), .in_slot(in_slot),
        .task_arvalid(task_arvalid), .task_araddr(task_araddr),
        .task_rvalid(task_rvalid), .task_rdata(task_rdata), .task_rslot(task_rslot),
        .start_task_valid(start_task_valid), .start_task_ready(start_task_ready),
        .start_task_slot(start_task_slot),
        .finish_task_valid(finish_task_valid), .finish_task_ready(finish_task_ready),
        .finish_task_slot(finish_task_slot),
        .finish_task_num_children(finish_task_num_children),
        .finish_task_undo_log_write(finish_task_undo_log_write),
        .abort_req_valid(abort_req_valid), .abort_req_slot(abort_req_slot),
        .abort_req_hit(abort_req_hit), .abort_running_task(abort_running_task),
        .abort_running_slot(abort_running_slot),
        .done_valid(done_valid), .done_ready(done_ready), .done_slot(done_slot),
        .done_children(done_children), .done_undo(done_undo),
        .done_aborted(done_aborted), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [SLOT_W-1:0] slot;
        logic [TASK_W-1:0] data;
    } tq_t;

    typedef struct packed {
        logic [SLOT_W-1:0]  slot;
        logic [CHILD_W-1:0] ch;
        logic               undo;
        logic               ab;
    } dq_t;

    // mode: 0 plain, 1 abort before finish, 2 abort with finish, 3 abort of other slot
    typedef struct {
        logic [SLOT_W-1:0]  slot;
        logic [TTYPE_W-1:0] tt;
        logic [CHILD_W-1:0] ch;
        logic               undo;
        int                 mode;
        logic               exp_ab;
    } vec_t;

    int checks = 0;
    int errors = 0;
    tq_t sb_task[$];
    dq_t sb_done[$];
    vec_t vecs[5];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_in_ready"},   128'(in_ready), 128'(0));
        chk({tag, "_rvalid"},     128'(task_rvalid), 128'(0));
        chk({tag, "_start_rdy"},  128'(start_task_ready), 128'(0));
        chk({tag, "_finish_rdy"}, 128'(finish_task_ready), 128'(0));
        chk({tag, "_done_valid"}, 128'(done_valid), 128'(0));
        chk({tag, "_abort_hit"},  128'(abort_req_hit), 128'(0));
        chk({tag, "_abort_task"}, 128'(abort_running_task), 128'(0));
        chk({tag, "_done_ab"},    128'(done_aborted), 128'(0));
        chk({tag, "_proto_err"},  128'(proto_err), 128'(0));
    endtask

    task automatic push_task(input logic [SLOT_W-1:0] slot, input logic [TTYPE_W-1:0] tt,
                             input logic exp_ready);
        tq_t e;
        e.slot = slot;
        e.data = {$urandom, $urandom, $urandom, $urandom};
        in_valid = 1; in_task = e.data; in_ttype = tt; in_slot = slot;
        #1;
        chk("in_ready", 128'(in_ready), 128'(exp_ready));
        if (in_ready) sb_task.push_back(e);
        cyc();
        in_valid = 0;
    endtask

    task automatic take_head();
        tq_t e;
        if (sb_task.size() == 0) begin
            errors++;
            $display("FAIL sb_task_unexpected: got slot %0h expected none", task_rslot);
        end else begin
            e = sb_task.pop_front();
            chk("task_rslot", 128'(task_rslot), 128'(e.slot));
            chk("task_rdata", task_rdata, e.data);
        end
    endtask

    task automatic deq_task(input logic [TTYPE_W-1:0] ar, input logic exp_rv);
        task_arvalid = 1; task_araddr = ar;
        #1;
        chk("task_rvalid", 128'(task_rvalid), 128'(exp_rv));
        if (task_rvalid) take_head();
        cyc();
        task_arvalid = 0;
    endtask

    task automatic wait_done();
        dq_t e;
        bit seen = 0;
        for (int i = 0; i < 8 && !seen; i++) begin
            #1;
            if (done_valid) begin
                seen = 1;
                done_ready = 1;
                if (sb_done.size() == 0) begin
                    errors++;
                    $display("FAIL done_unexpected: got slot %0h expected none", done_slot);
                end else begin
                    e = sb_done.pop_front();
                    chk("done_slot",     128'(done_slot), 128'(e.slot));
                    chk("done_children", 128'(done_children), 128'(e.ch));
                    chk("done_undo",     128'(done_undo), 128'(e.undo));
                    chk("done_aborted",  128'(done_aborted), 128'(e.ab));
                end
            end
            cyc();
            done_ready = 0;
        end
        if (!seen) begin
            errors++;
            $display("FAIL done_timeout: got no done_valid expected one within 8 cycles");
        end
    endtask

    task automatic complete(input logic [SLOT_W-1:0] slot, input logic [CHILD_W-1:0] ch,
                            input logic undo, input int mode, input logic exp_ab);
        start_task_valid = 1; start_task_slot = slot;
        #1;
        chk("start_ready", 128'(start_task_ready), 128'(1));
        cyc();
        start_task_valid = 0;
        if (mode == 1 || mode == 3) begin
            abort_req_valid = 1;
            abort_req_slot = (mode == 1) ? slot : (slot ^ 7'd1);
            cyc();
            abort_req_valid = 0;
            #1;
            chk("abort_hit",  128'(abort_req_hit), 128'(mode == 1));
            chk("abort_task", 128'(abort_running_task), 128'(mode == 1));
            if (mode == 1) chk("abort_slot", 128'(abort_running_slot), 128'(slot));
        end
        finish_task_valid = 1; finish_task_slot = slot;
        finish_task_num_children = ch; finish_task_undo_log_write = undo;
        if (mode == 2) begin
            abort_req_valid = 1; abort_req_slot = slot;
        end
        #1;
        chk("finish_ready", 128'(finish_task_ready), 128'(1));
        sb_done.push_back({slot, ch, undo, exp_ab});
        cyc();
        finish_task_valid = 0; abort_req_valid = 0;
        chk("abort_task_drop", 128'(abort_running_task), 128'(0));
        wait_done();
    endtask

    task automatic reset_dut(input string tag);
        rstn = 0;
        #1;
        check_zero(tag);
        sb_task.delete();
        sb_done.delete();
        cyc();
        rstn = 1;
        cyc();
        cyc();
        chk({tag, "_in_ready_after"}, 128'(in_ready), 128'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected bench end");
        $fatal(1);
    end

    initial begin
        tq_t e;
        vecs[0] = '{slot: 7'd5,   tt: 4'd0,  ch: 3'd2, undo: 1'b1, mode: 0, exp_ab: 1'b0};
        vecs[1] = '{slot: 7'd9,   tt: 4'd2,  ch: 3'd1, undo: 1'b0, mode: 1, exp_ab: 1'b1};
        vecs[2] = '{slot: 7'd9,   tt: 4'd6,  ch: 3'd4, undo: 1'b1, mode: 3, exp_ab: 1'b0};
        vecs[3] = '{slot: 7'd33,  tt: 4'd15, ch: 3'd7, undo: 1'b1, mode: 2, exp_ab: 1'b1};
        vecs[4] = '{slot: 7'd127, tt: 4'd3,  ch: 3'd0, undo: 1'b0, mode: 0, exp_ab: 1'b0};

        #2;
        reset_dut("reset");

        for (int i = 0; i < 5; i++) begin
            push_task(vecs[i].slot, vecs[i].tt, 1'b1);
            deq_task(vecs[i].tt, 1'b1);
            complete(vecs[i].slot, vecs[i].ch, vecs[i].undo, vecs[i].mode, vecs[i].exp_ab);
        end

        // abort matching the stale cur_slot while idle has no effect
        abort_req_valid = 1; abort_req_slot = 7'd127;
        cyc();
        abort_req_valid = 0;
        chk("idle_abort_hit",  128'(abort_req_hit), 128'(0));
        chk("idle_abort_task", 128'(abort_running_task), 128'(0));

        // fill, full back-pressure, simultaneous push/pop, drain across wrap
        for (int i = 0; i < 4; i++) push_task(7'(10 + i), 4'd0, 1'b1);
        push_task(7'd99, 4'd0, 1'b0);
        deq_task(4'd0, 1'b1);
        complete(7'd10, 3'd1, 1'b0, 0, 1'b0);
        e.slot = 7'd14;
        e.data = {$urandom, $urandom, $urandom, $urandom};
        in_valid = 1; in_task = e.data; in_ttype = 4'd0; in_slot = e.slot;
        task_arvalid = 1; task_araddr = 4'd0;
        #1;
        chk("simul_rvalid",   128'(task_rvalid), 128'(1));
        chk("simul_in_ready", 128'(in_ready), 128'(1));
        if (task_rvalid) take_head();
        if (in_ready) sb_task.push_back(e);
        cyc();
        in_valid = 0; task_arvalid = 0;
        complete(7'd11, 3'd3, 1'b1, 0, 1'b0);
        push_task(7'd15, 4'd0, 1'b1);
        chk("full_again", 128'(in_ready), 128'(0));
        for (int i = 0; i < 4; i++) begin
            deq_task(4'd0, 1'b1);
            complete(7'(12 + i), 3'(i), 1'b1, 0, 1'b0);
        end

        // ttype mismatch at head stalls dequeue
        push_task(7'd20, 4'd1, 1'b1);
        repeat (3) deq_task(4'd0, 1'b0);
        deq_task(4'd1, 1'b1);
        complete(7'd20, 3'd2, 1'b0, 0, 1'b0);

        // abort in DISPATCHED then finish without start
        push_task(7'd40, 4'd0, 1'b1);
        deq_task(4'd0, 1'b1);
        abort_req_valid = 1; abort_req_slot = 7'd40;
        cyc();
        abort_req_valid = 0;
        chk("disp_abort_hit",  128'(abort_req_hit), 128'(1));
        chk("disp_abort_task", 128'(abort_running_task), 128'(1));
        finish_task_valid = 1; finish_task_slot = 7'd40;
        #1;
        chk("disp_finish_ready", 128'(finish_task_ready), 128'(0));
        cyc();
        finish_task_valid = 0;
        chk("disp_proto_err", 128'(proto_err), 128'(1));
        chk("disp_no_done",   128'(done_valid), 128'(0));
        reset_dut("rst5");

        // finish slot mismatch in RUNNING
        push_task(7'd42, 4'd0, 1'b1);
        deq_task(4'd0, 1'b1);
        start_task_valid = 1; start_task_slot = 7'd42;
        cyc();
        start_task_valid = 0;
        chk("mm_err_before", 128'(proto_err), 128'(0));
        finish_task_valid = 1; finish_task_slot = 7'd43;
        finish_task_num_children = 3'd5; finish_task_undo_log_write = 1'b0;
        #1;
        chk("mm_finish_ready", 128'(finish_task_ready), 128'(1));
        sb_done.push_back({7'd42, 3'd5, 1'b0, 1'b0});
        cyc();
        finish_task_valid = 0;
        chk("mm_proto_err", 128'(proto_err), 128'(1));
        wait_done();

        // reset mid-RUNNING discards everything
        reset_dut("rst6a");
        push_task(7'd50, 4'd0, 1'b1);
        push_task(7'd51, 4'd0, 1'b1);
        deq_task(4'd0, 1'b1);
        start_task_valid = 1; start_task_slot = 7'd50;
        cyc();
        start_task_valid = 0;
        #1;
        chk("pre_rst_running", 128'(finish_task_ready), 128'(1));
        reset_dut("rst6");
        deq_task(4'd0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
